bit_serial_mult_ctrl: RTL and testbench
=======================================

// Module: bit_serial_mult_ctrl
// PURPOSE
//  Sequencer for one bit_serial_multiplier instance.
//  - Accepts parallel N-bit signed operands on a valid/ready handshake.
//  - Streams them LSB-first into the multiplier: bits 0..N-1, then sign bit repeated to K=2N.
//  - Drives first_bit/last_bit framing and deserialises p into a 2N-bit product.
//  - Presents the product on a valid/ready output. Sits between the parallel datapath and the serial multiplier.
// PARAMETERS
//  N      4     operand width (bits, two's complement); product width K=2N
//  ACC_W  16    accumulator width, used only with BSM_CTRL_ACCUM_EN; ACC_W >= 2N
// PORTS
//  clk            in   1     single clock, all logic on posedge
//  aresetn        in   1     reset, synchronous, active-low
//  in_valid       in   1     operand pair offered
//  in_ready       out  1     controller can accept operands
//  in_a           in   N     operand A (signed)
//  in_b           in   N     operand B (signed)
//  out_valid      out  1     product/accumulator result available
//  out_ready      in   1     consumer accepts result
//  out_product    out  2N    signed product a*b
//  mul_x          out  1     serial A bit to multiplier
//  mul_y          out  1     serial B bit to multiplier
//  mul_first_bit  out  1     high during bit 0 only
//  mul_last_bit   out  1     low while an operation is in flight, high otherwise
//  mul_p          in   1     serial product bit from multiplier, valid in same cycle as mul_x/mul_y
// BEHAVIOUR
//  Reset (aresetn=0 at posedge):
//  - state=IDLE; in_ready=1, out_valid=0, out_product=0.
//  - mul_x=mul_y=mul_first_bit=0, mul_last_bit=1.
//  - Bit counter=0; accumulator=0.
//  FSM states:
//  - IDLE -> SHIFT on in_valid&&in_ready: latch in_a/in_b into shift regs, cnt=0.
//  - SHIFT: cnt 0..K-1. mul_x/mul_y = operand bit cnt for cnt<N, else bit N-1 (sign extension).
//    mul_first_bit=(cnt==0). prod[cnt]<=mul_p at end of cycle. -> FLUSH after cnt==K-1.
//  - FLUSH: 2 cycles with mul_last_bit=0, mul_x=mul_y=sign bit, then -> DONE.
//  - DONE: out_valid=1, out_product stable; -> IDLE on out_ready.
//  Outputs and timing:
//  - mul_last_bit=0 in SHIFT and FLUSH, 1 in IDLE and DONE.
//  - in_ready=1 only in IDLE; no new operation accepted until the result is taken.
//  - Latency: accept edge at cycle 0 -> out_valid high from cycle K+3; throughput 1 op per K+4 cycles minimum.
//  - out_valid held, out_product unchanged, under out_ready=0 backpressure (any number of cycles).
//  - in_valid while busy: ignored, no state change; the offering side must hold its data.
//  - Arithmetic: result = low 2N bits of signed a*b; exact for all N-bit signed pairs.
//  - Reset mid-SHIFT/FLUSH/DONE: operation discarded, no out_valid pulse; mul_last_bit=1 next cycle.
// CONFIGURATION
//  BSM_CTRL_ACCUM_EN defined:
//  - Adds input in_clr (1, pulse in IDLE) and output out_acc (ACC_W).
//  - On DONE->IDLE: acc <= acc + sign-extended out_product, wraps modulo 2^ACC_W.
//  - in_clr in IDLE zeroes acc; in_clr outside IDLE is ignored; in_clr coincident with accept clears acc before the new op.
//  BSM_CTRL_ACCUM_EN undefined: no accumulator, no in_clr/out_acc ports.
// STRUCTURE
//  Package bit_serial_mult_ctrl_pkg:
//  - typedef enum {IDLE,SHIFT,FLUSH,DONE} bsm_state_t; localparam FLUSH_CYCLES=2.
//  - Function sext() for product->ACC_W.
//  Sub-module bsm_piso (N-bit load, sign-extending shift register), instanced once per operand.
//  bit_serial_multiplier is not instanced here; connected at the parent level.
// TESTING  (N=4, bench instances controller plus bit_serial_multiplier)
//  - a=5,b=7 -> out_product=8'd35, out_valid at cycle K+3=11 after accept; first_bit high exactly 1 cycle.
//  - a=-3,b=2 -> 8'hFA (-6); a=-8,b=-8 -> 8'h40 (64).
//  - Exhaustive a,b in -8..7 against a*b; in_valid held high while busy accepts nothing extra.
//  - a=3,b=3 with out_ready=0 for 20 cycles -> out_valid/out_product=9 stable, in_ready=0 throughout.
//  - aresetn=0 at SHIFT cnt=3 -> next cycle IDLE, mul_last_bit=1, no out_valid; next op 2*6=12 correct.
//  - ACCUM_EN: in_clr, then 3*3, 2*2 -> out_acc=13; then -7*1 -> 6; in_clr -> 0.

Source files
------------

// File: rtl/bit_serial_mult_ctrl_pkg.sv
// Shared types and helpers for the bit-serial multiplier sequencer.
// The BSM_CTRL_ACCUM_EN build uses sext() to widen products into the accumulator.
package bit_serial_mult_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } bsm_state_t;

  localparam int FLUSH_CYCLES = 2;
  localparam int SEXT_MAX     = 64;

  // Sign-extend the low 'width' bits of v to the full SEXT_MAX width.
  function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] v,
                                               input int width);
    logic [SEXT_MAX-1:0] t;
    t = v << (SEXT_MAX - width);
    return SEXT_MAX'($signed(t) >>> (SEXT_MAX - width));
  endfunction

endpackage

// File: rtl/bit_serial_mult_ctrl_piso.sv
// Parallel-load shift register that emits its operand LSB-first and then
// keeps presenting the sign bit once the magnitude bits are exhausted.
module bsm_piso #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic         bit_out
);

  logic [N-1:0] sr;

  // Arithmetic right shift: the MSB is replicated so the sign keeps flowing out.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[N-1], sr[N-1:1]};
    end
  end

  assign bit_out = sr[0];

endmodule

// File: rtl/bit_serial_mult_ctrl.sv
// Sequencer feeding one bit-serial multiplier and collecting its 2N-bit product.
// Define BSM_CTRL_ACCUM_EN to add the running accumulator (in_clr / out_acc).
module bit_serial_mult_ctrl
  import bit_serial_mult_ctrl_pkg::*;
#(
  parameter int N     = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
`ifdef BSM_CTRL_ACCUM_EN
  input  logic             in_clr,
  output logic [ACC_W-1:0] out_acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_product,
  output logic             mul_x,
  output logic             mul_y,
  output logic             mul_first_bit,
  output logic             mul_last_bit,
  input  logic             mul_p
);

  localparam int K    = 2 * N;
  localparam int CNT_W = $clog2(K + 1);
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  bsm_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [FC_W-1:0]  fcnt;
  logic [K-1:0]     prod;
  logic             accept;
  logic             busy;
  logic             a_bit, b_bit;

  bsm_piso #(.N(N)) u_piso_a (
    .clk     (clk),
    .aresetn (aresetn),
    .load    (accept),
    .shift   (state == SHIFT),
    .din     (in_a),
    .bit_out (a_bit)
  );

  bsm_piso #(.N(N)) u_piso_b (
    .clk     (clk),
    .aresetn (aresetn),
    .load    (accept),
    .shift   (state == SHIFT),
    .din     (in_b),
    .bit_out (b_bit)
  );

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Serial bits are only driven while an operation is in flight.
  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    busy          = 1'b0;
    mul_first_bit = 1'b0;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy          = 1'b1;
        mul_first_bit = (cnt == '0);
        if (cnt == CNT_W'(K - 1)) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (fcnt == FC_W'(FLUSH_CYCLES - 1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mul_last_bit = !busy;
  assign mul_x        = busy & a_bit;
  assign mul_y        = busy & b_bit;
  assign out_product  = prod;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      cnt  <= '0;
      fcnt <= '0;
      prod <= '0;
    end else begin
      if (accept) begin
        cnt  <= '0;
        fcnt <= '0;
      end
      if (state == SHIFT) begin
        prod[cnt] <= mul_p;
        cnt       <= cnt + 1'b1;
      end
      if (state == FLUSH) fcnt <= fcnt + 1'b1;
    end
  end

`ifdef BSM_CTRL_ACCUM_EN
  logic [ACC_W-1:0] acc;

  // A clear in IDLE wins over the accept of the same cycle, so the new op lands on zero.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      acc <= '0;
    end else if (state == IDLE && in_clr) begin
      acc <= '0;
    end else if (state == DONE && out_ready) begin
      acc <= acc + ACC_W'(sext({{(SEXT_MAX-K){1'b0}}, prod}, K));
    end
  end

  assign out_acc = acc;
`endif

endmodule

// File: tb/tb_bit_serial_mult_ctrl.sv
// Directed bench for bit_serial_mult_ctrl (N=4) with a behavioural serial multiplier.
// Define BSM_CTRL_ACCUM_EN to also exercise the accumulator.
module tb_bit_serial_mult_ctrl;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_product;
  logic       mul_x, mul_y, mul_first_bit, mul_last_bit;
  logic       mul_p;
`ifdef BSM_CTRL_ACCUM_EN
  logic        in_clr = 1'b0;
  logic [15:0] out_acc;
`endif

  int errors = 0;
  int checks = 0;

  bit_serial_mult_ctrl #(.N(4), .ACC_W(16)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
`ifdef BSM_CTRL_ACCUM_EN
    .in_clr        (in_clr),
    .out_acc       (out_acc),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_product   (out_product),
    .mul_x         (mul_x),
    .mul_y         (mul_y),
    .mul_first_bit (mul_first_bit),
    .mul_last_bit  (mul_last_bit),
    .mul_p         (mul_p)
  );

  always #5 clk = ~clk;

  // Stand-in serial multiplier: product bit i depends only on operand bits 0..i.
  logic [15:0] mx_acc = '0, my_acc = '0;
  int          bidx = 0;
  logic [15:0] xf, yf, pf;
  int          bi;

  always_comb begin
    bi    = mul_first_bit ? 0 : bidx;
    xf    = mul_first_bit ? 16'd0 : mx_acc;
    yf    = mul_first_bit ? 16'd0 : my_acc;
    pf    = '0;
    mul_p = 1'b0;
    if (!mul_last_bit && bi < 8) begin
      xf[bi] = mul_x;
      yf[bi] = mul_y;
      pf     = xf * yf;
      mul_p  = pf[bi];
    end
  end

  always @(posedge clk) begin
    if (!mul_last_bit && bi < 8) begin
      mx_acc <= xf;
      my_acc <= yf;
      bidx   <= bi + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offers one operand pair and waits (bounded) for out_valid; leaves the result untaken.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input bit hold,
                               output int cyc, output int fb, output int rdy);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    checkOutput("accept_ready", in_ready, 1);
    @(posedge clk);
    cyc = 0;
    fb  = 0;
    rdy = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        in_a = ~a;
        in_b = ~b;
      end else begin
        in_valid = 1'b0;
      end
      fb += int'(mul_first_bit);
      if (!out_valid) rdy += int'(in_ready);
    end while (!out_valid && cyc < 40);
    in_valid = 1'b0;
    checkOutput("op_valid", out_valid, 1);
  endtask

  task automatic takeResult();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("taken_valid", out_valid, 0);
    checkOutput("taken_ready", in_ready, 1);
  endtask

  task automatic runAndCheck(input string tag, input logic [3:0] a, input logic [3:0] b,
                             input logic [7:0] exp, input bit hold);
    int cyc, fb, rdy;
    applyStimulus(a, b, hold, cyc, fb, rdy);
    checkOutput({tag, "_prod"}, out_product, exp);
    checkOutput({tag, "_latency"}, cyc, 11);
    checkOutput({tag, "_first_bit"}, fb, 1);
    checkOutput({tag, "_busy_ready"}, rdy, 0);
    takeResult();
  endtask

  initial begin
    int seen;
    logic [7:0] e;

    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_product", out_product, 0);
    checkOutput("rst_mul_x", mul_x, 0);
    checkOutput("rst_mul_y", mul_y, 0);
    checkOutput("rst_first_bit", mul_first_bit, 0);
    checkOutput("rst_last_bit", mul_last_bit, 1);
    aresetn = 1'b1;
    @(negedge clk);

    runAndCheck("p5x7", 4'd5, 4'd7, 8'd35, 1'b0);
    runAndCheck("m3x2", 4'hD, 4'd2, 8'hFA, 1'b0);
    runAndCheck("m8xm8", 4'h8, 4'h8, 8'h40, 1'b0);

    $display("[TB] exhaustive sweep with in_valid held while busy");
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        e = 8'(a * b);
        runAndCheck("sweep", 4'(a), 4'(b), e, 1'b1);
      end
    end

    begin
      int cyc, fb, rdy;
      applyStimulus(4'd3, 4'd3, 1'b0, cyc, fb, rdy);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        checkOutput("bp_valid", out_valid, 1);
        checkOutput("bp_prod", out_product, 8'd9);
        checkOutput("bp_ready", in_ready, 0);
      end
      takeResult();
    end

    in_a     = 4'd5;
    in_b     = 4'd5;
    in_valid = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("mid_last_bit", mul_last_bit, 0);
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    checkOutput("abort_last_bit", mul_last_bit, 1);
    checkOutput("abort_ready", in_ready, 1);
    checkOutput("abort_valid", out_valid, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen += int'(out_valid);
    end
    checkOutput("abort_no_valid", seen, 0);
    runAndCheck("p2x6", 4'd2, 4'd6, 8'd12, 1'b0);

`ifdef BSM_CTRL_ACCUM_EN
    in_clr = 1'b1;
    @(negedge clk);
    in_clr = 1'b0;
    checkOutput("acc_clr0", out_acc, 16'd0);
    runAndCheck("acc3x3", 4'd3, 4'd3, 8'd9, 1'b0);
    runAndCheck("acc2x2", 4'd2, 4'd2, 8'd4, 1'b0);
    checkOutput("acc_13", out_acc, 16'd13);
    runAndCheck("accm7x1", 4'h9, 4'd1, 8'hF9, 1'b0);
    checkOutput("acc_6", out_acc, 16'd6);
    in_clr = 1'b1;
    @(negedge clk);
    in_clr = 1'b0;
    checkOutput("acc_clr1", out_acc, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
